icache_nwa_wide: RTL and testbench

//  N-way set-associative read-only instruction cache; fills a whole line per miss over a wide memory port.

---
 rtl/icache_nwa_wide.sv | 229 ++++++++++++++++++++++
 tb/tb_icache_nwa_wide.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nwa_wide.sv
// icache_nwa_wide
//   N-way set-associative, read-only instruction cache between the core fetch
//   port and instruction memory. A miss fetches a whole line in one beat over
//   a wide memory port. The requested word is forwarded to the core on the
//   fill edge. Victims are chosen as the lowest invalid way, or else by a
//   round-robin pointer per set. Flush invalidates every line. Saturating
//   hit and miss counters are provided.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   flush              one-cycle pulse that invalidates all lines
//   proc_valid/ready   fetch handshake; proc_addr is held while proc_valid=1
//   proc_addr          fetch byte address
//   proc_rdata         fetched word
//   mem_req_valid      line-fill request, held until mem_req_ready
//   mem_req_ready      fill data present on mem_req_rdata this cycle
//   mem_req_addr       line-aligned fill address
//   mem_req_rdata      full line, word 0 in the LSBs
//   hit_count          saturating hit counter
//   miss_count         saturating miss counter
module icache_nwa_wide #(
    parameter int CACHE_SIZE = 1024,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                flush,
    input  logic                                proc_valid,
    output logic                                proc_ready,
    input  logic [31:0]                         proc_addr,
    output logic [8*BLOCK_SIZE-1:0]             proc_rdata,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [31:0]                         mem_req_addr,
    input  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  mem_req_rdata,
    output logic [31:0]                         hit_count,
    output logic [31:0]                         miss_count
);

    localparam int DW    = 8 * BLOCK_SIZE;
    localparam int LW    = DW * NUM_BLOCKS;
    localparam int SETS  = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * 4);
    localparam int OB    = $clog2(NUM_BLOCKS);
    localparam int IB    = $clog2(SETS);
    localparam int TAG_W = 32 - IB - OB - 2;
    localparam int WB    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_t;

    state_t               state;
    logic                 flush_pending;

    logic [LW-1:0]        data_q  [NUM_WAYS][SETS];
    logic [TAG_W-1:0]     tag_q   [NUM_WAYS][SETS];
    logic [NUM_WAYS-1:0]  valid_q [SETS];
    logic [WB-1:0]        rr_q    [SETS];

    logic [OB-1:0]        lat_off;
    logic [IB-1:0]        lat_idx;
    logic [TAG_W-1:0]     lat_tag;

    logic [OB-1:0]        req_off;
    logic [IB-1:0]        req_idx;
    logic [TAG_W-1:0]     req_tag;

    logic                 hit_any;
    logic                 lookup_hit;
    logic [WB-1:0]        hit_way;
    logic [LW-1:0]        hit_line;
    logic [DW-1:0]        hit_word;
    logic [DW-1:0]        fill_word;

    logic [WB-1:0]        victim;
    logic                 all_valid;

    // The byte offset within a word is irrelevant to a word-wide fetch.
    logic                 unused_byte_bits;
    assign unused_byte_bits = ^proc_addr[1:0];

    assign req_off = proc_addr[OB+1:2];
    assign req_idx = proc_addr[OB+2 +: IB];
    assign req_tag = proc_addr[31 -: TAG_W];

    // The loop runs downward, so the lowest-numbered hitting way is the one
    // that ends up selected.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    // A flush in the same cycle as the lookup forces a miss, so stale data
    // can never be returned.
    assign lookup_hit = hit_any && !flush;
    assign hit_line   = data_q[hit_way][req_idx];
    assign hit_word   = hit_line[req_off*DW +: DW];
    assign fill_word  = mem_req_rdata[lat_off*DW +: DW];

    // The lowest invalid way is filled first. Only a full set falls back to
    // the round-robin pointer.
    always_comb begin
        victim    = rr_q[lat_idx];
        all_valid = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lat_idx][w]) begin
                victim    = WB'(w);
                all_valid = 1'b0;
            end
        end
    end

    // Line data and tags carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_req_ready) begin
            data_q[victim][lat_idx] <= mem_req_rdata;
            tag_q[victim][lat_idx]  <= lat_tag;
        end
    end

    // A flush seen while busy is deferred to the edge that returns to IDLE.
    // That deferred flush also invalidates the line just installed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            proc_ready    <= 1'b0;
            proc_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            lat_off       <= '0;
            lat_idx       <= '0;
            lat_tag       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                    end
                    if (proc_valid) begin
                        if (lookup_hit) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= hit_word;
                            if (hit_count != 32'hFFFF_FFFF) begin
                                hit_count <= hit_count + 32'd1;
                            end
                            state <= RESP;
                        end else begin
                            lat_off       <= req_off;
                            lat_idx       <= req_idx;
                            lat_tag       <= req_tag;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {proc_addr[31:OB+2], {(OB+2){1'b0}}};
                            if (miss_count != 32'hFFFF_FFFF) begin
                                miss_count <= miss_count + 32'd1;
                            end
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid            <= 1'b0;
                        valid_q[lat_idx][victim] <= 1'b1;
                        if (all_valid && (NUM_WAYS > 1)) begin
                            rr_q[lat_idx] <= rr_q[lat_idx] + WB'(1);
                        end
                        if (proc_valid) begin
                            proc_ready <= 1'b1;
                            proc_rdata <= fill_word;
                            state      <= RESP;
                        end else begin
                            state <= IDLE;
                            if (flush || flush_pending) begin
                                flush_pending <= 1'b0;
                                for (int s = 0; s < SETS; s++) begin
                                    valid_q[s] <= '0;
                                end
                            end
                        end
                    end
                end

                RESP: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (!proc_valid) begin
                        proc_ready <= 1'b0;
                        state      <= IDLE;
                        if (flush || flush_pending) begin
                            flush_pending <= 1'b0;
                            for (int s = 0; s < SETS; s++) begin
                                valid_q[s] <= '0;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_nwa_wide.sv
// tb_icache_nwa_wide
//   Scoreboard bench for icache_nwa_wide using the default geometry: 2 ways,
//   4 words per line, 32 sets. The memory returns a line whose words are a
//   fixed function of their address. The expected word is queued when a
//   fetch is issued and popped when proc_ready is seen. Expected hit/miss
//   counts and fill counts come from the cache behaviour each read should
//   produce.
module tb_icache_nwa_wide;

    logic          clk;
    logic          resetn;
    logic          flush;
    logic          proc_valid;
    logic          proc_ready;
    logic [31:0]   proc_addr;
    logic [31:0]   proc_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic [127:0]  mem_req_rdata;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    int            tests_run;
    int            tests_failed;
    logic [31:0]   exp_q[$];
    logic [31:0]   exp_hits;
    logic [31:0]   exp_misses;
    int            exp_fills;
    int            fill_count;
    logic [31:0]   last_fill_addr;
    int            mem_lat;
    int            wait_cnt;

    icache_nwa_wide dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .proc_valid    (proc_valid),
        .proc_ready    (proc_ready),
        .proc_addr     (proc_addr),
        .proc_rdata    (proc_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_rdata (mem_req_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of memory: every word is distinct and derived from its address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] w;
        w = {addr[31:2], 2'b00};
        return {w[27:0], 4'h0} ^ 32'h5A00_C3A5 ^ {30'd0, addr[3:2]};
    endfunction

    function automatic logic [127:0] memLine(input logic [31:0] base);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*32 +: 32] = memWord({base[31:4], 4'h0} + 32'(i * 4));
        end
        return l;
    endfunction

    // Memory responder: raises mem_req_ready for one cycle, mem_lat negedges
    // after it first sees a request.
    always @(negedge clk) begin
        if (mem_req_valid) begin
            if (wait_cnt == mem_lat) begin
                mem_req_ready  = 1'b1;
                mem_req_rdata  = memLine(mem_req_addr);
                last_fill_addr = mem_req_addr;
                fill_count++;
                wait_cnt = 0;
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_req_ready = 1'b0;
            wait_cnt      = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Issue one fetch and check its data, latency, counters and fill traffic.
    task automatic applyStimulus(input logic [31:0] addr, input bit exp_hit,
                                 input bit flush_mid);
        int          cyc;
        logic [31:0] exp_word;
        @(negedge clk);
        proc_addr  = addr;
        proc_valid = 1'b1;
        exp_q.push_back(memWord(addr));
        if (exp_hit) exp_hits = satInc(exp_hits);
        else begin
            exp_misses = satInc(exp_misses);
            exp_fills++;
        end
        cyc = 0;
        while (!proc_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
            flush = flush_mid && (cyc == 1);
        end
        flush    = 1'b0;
        exp_word = exp_q.pop_front();
        if (!proc_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("rdata", proc_rdata, exp_word);
            checkOutput("latency", 32'(cyc), exp_hit ? 32'd1 : 32'(2 + mem_lat));
        end
        checkOutput("hit_count", hit_count, exp_hits);
        checkOutput("miss_count", miss_count, exp_misses);
        checkOutput("fill_count", 32'(fill_count), 32'(exp_fills));
        proc_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_drop", {31'd0, proc_ready}, 32'd0);
    endtask

    initial begin
        int ready_seen;
        tests_run    = 0;
        tests_failed = 0;
        exp_hits     = '0;
        exp_misses   = '0;
        exp_fills    = 0;
        fill_count   = 0;
        wait_cnt     = 0;
        mem_lat      = 2;
        last_fill_addr = '0;
        mem_req_ready  = 1'b0;
        mem_req_rdata  = '0;
        resetn     = 1'b0;
        flush      = 1'b0;
        proc_valid = 1'b0;
        proc_addr  = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_proc_ready", {31'd0, proc_ready}, 32'd0);
        checkOutput("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rst_mem_addr", mem_req_addr, 32'd0);
        checkOutput("rst_rdata", proc_rdata, 32'd0);
        checkOutput("rst_hits", hit_count, 32'd0);
        checkOutput("rst_misses", miss_count, 32'd0);
        resetn = 1'b1;

        // Cold miss returns the critical word, then a hit in the same line.
        applyStimulus(32'h104, 1'b0, 1'b0);
        checkOutput("t1_fill_addr", last_fill_addr, 32'h100);
        applyStimulus(32'h10C, 1'b1, 1'b0);

        // Flush in IDLE invalidates the line.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(32'h100, 1'b0, 1'b0);
        checkOutput("t4_fill_addr", last_fill_addr, 32'h100);

        // Set 0 replacement: invalid ways first, then round-robin.
        mem_lat = 1;
        applyStimulus(32'h000, 1'b0, 1'b0);
        applyStimulus(32'h200, 1'b0, 1'b0);
        applyStimulus(32'h400, 1'b0, 1'b0);
        applyStimulus(32'h200, 1'b1, 1'b0);
        applyStimulus(32'h000, 1'b0, 1'b0);
        applyStimulus(32'h200, 1'b0, 1'b0);

        // Abandoned miss: the fill still completes, with no response.
        mem_lat = 6;
        @(negedge clk);
        proc_addr  = 32'h040;
        proc_valid = 1'b1;
        exp_misses = satInc(exp_misses);
        exp_fills++;
        @(negedge clk);
        @(negedge clk);
        proc_valid = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (proc_ready) ready_seen++;
        end
        checkOutput("t3_no_ready", 32'(ready_seen), 32'd0);
        checkOutput("t3_fill_count", 32'(fill_count), 32'(exp_fills));
        checkOutput("t3_mem_idle", {31'd0, mem_req_valid}, 32'd0);
        mem_lat = 1;
        applyStimulus(32'h044, 1'b1, 1'b0);

        // Flush during FILL also drops the line being filled.
        mem_lat = 3;
        applyStimulus(32'h300, 1'b0, 1'b1);
        mem_lat = 1;
        applyStimulus(32'h300, 1'b0, 1'b0);
        applyStimulus(32'h104, 1'b0, 1'b0);
        applyStimulus(32'h104, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a fill.
        mem_lat = 5;
        @(negedge clk);
        proc_addr  = 32'h500;
        proc_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_in_fill", {31'd0, mem_req_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t5_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("t5_proc_ready", {31'd0, proc_ready}, 32'd0);
        checkOutput("t5_misses", miss_count, 32'd0);
        proc_valid = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        exp_hits   = '0;
        exp_misses = '0;
        mem_lat    = 1;
        applyStimulus(32'h104, 1'b0, 1'b0);

        // Hit counter saturation.
        @(negedge clk);
        force dut.hit_count = 32'hFFFF_FFFE;
        #1;
        release dut.hit_count;
        exp_hits = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h108, 1'b1, 1'b0);
        end
        checkOutput("t6_saturated", hit_count, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
